// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory bus, IF/ID hand-off and redirect signals.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/memory.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall_in;
  logic             redirect_in;
  logic [WIDTH-1:0] redirect_pc_in;
  logic             imem_req_out;
  logic [WIDTH-1:0] imem_addr_out;
  logic             imem_ack_in;
  logic [WIDTH-1:0] imem_rdata_in;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] instr_out;
  logic             valid_out;

  modport master (
    input  stall_in, redirect_in, redirect_pc_in, imem_ack_in, imem_rdata_in,
    output imem_req_out, imem_addr_out, pc_out, instr_out, valid_out
  );

  modport slave (
    output stall_in, redirect_in, redirect_pc_in, imem_ack_in, imem_rdata_in,
    input  imem_req_out, imem_addr_out, pc_out, instr_out, valid_out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word request at a time, buffers up to two
// fetched {pc, instr} pairs for IF/ID, and flushes/redirects on taken branches.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk_in,
  input logic          rst_in,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q;
  logic             req_q;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0] fifo_pc_q    [2];
  logic [WIDTH-1:0] fifo_instr_q [2];

  logic             req;
  logic [WIDTH-1:0] addr;
  logic             push;
  logic             pop;
  logic             valid;

  // In REQ the fetch PC cannot move while a request is outstanding, so it is the held address.
  always_comb begin
    req  = 1'b0;
    addr = fetch_pc_q;
    case (state_q)
      IDLE: begin
        req = 1'b0;
      end
      REQ: begin
        req = (count_q < 2'd2) || req_q;
      end
      DROP: begin
        req  = 1'b1;
        addr = req_addr_q;
      end
      default: begin
        req = 1'b0;
      end
    endcase
  end

  assign valid = (count_q != 2'd0);
  assign pop   = valid && !bus.stall_in;
  assign push  = (state_q == REQ) && req && bus.imem_ack_in && !bus.redirect_in;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.redirect_in && req && !bus.imem_ack_in) begin
          state_d = DROP;
        end else begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (bus.imem_ack_in) begin
          state_d = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over both push and pop: everything buffered is on the wrong path.
    if (bus.redirect_in) begin
      fetch_pc_d = {bus.redirect_pc_in[WIDTH-1:2], 2'b00};
      count_d    = 2'd0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + WIDTH'(4);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= addr;
      req_q      <= req && !bus.imem_ack_in;
      count_q    <= count_d;
      if (bus.redirect_in) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  // Storage needs no reset; the head is masked by valid until an entry is written.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata_in;
    end
  end

  assign bus.imem_req_out  = req;
  assign bus.imem_addr_out = addr;
  assign bus.valid_out     = valid;
  assign bus.pc_out        = valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus.instr_out     = valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;

endmodule
